// File: rtl/addsub_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : addsub_pkg
// Brief   : Shared types for the pipelined adder/subtractor.
// Revision: 1.0
// ---------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  typedef struct packed {
    logic co;
    logic overflow;
    logic zero;
    logic neg;
  } addsub_flags_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_pipe_chunk.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : addsub_chunk
// Brief   : Combinational CHUNK-bit ripple slice built from fac cells.
// Revision: 1.0
// ---------------------------------------------------------------------------
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fac u_fac (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout     = c[CHUNK];
  // Carry into the slice MSB; only meaningful for overflow in the top slice.
  assign c_msb_in = c[CHUNK-1];

endmodule : addsub_chunk
`default_nettype wire

// File: rtl/fac.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : fac
// Brief   : One-bit full-adder cell.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fac (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule : fac
`default_nettype wire

// File: rtl/addsub_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : addsub_pipe
// Brief   : Pipelined W-bit add/sub, one CHUNK-bit ripple slice per stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int W     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         op,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic         co,
  output logic         overflow,
  output logic         zero,
  output logic         neg
);

  localparam int STAGES = (CHUNK >= 1) ? (W / CHUNK) : 1;

  if (CHUNK < 1 || (W % CHUNK) != 0) begin : g_cfg_err
    $error("addsub_pipe: W (%0d) must be a positive multiple of CHUNK (%0d)", W, CHUNK);
  end

  logic       adv;
  addsub_op_t op_sel;

  // Stage-k inputs: the x word rotates right by CHUNK per stage, so result
  // bits enter at the top and the finished word lands in natural order.
  logic [W-1:0]      st_acc [STAGES];
  logic [W-1:0]      st_y   [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_v;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign op_sel   = addsub_op_t'(op);

  assign st_acc[0] = x;
  assign st_y[0]   = (op_sel == OP_SUB) ? ~y : y;
  assign st_c[0]   = (op_sel == OP_SUB) ? ~ci : ci;
  assign st_v[0]   = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             c_msb_unused;
    logic [W-1:0]     acc_nxt;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (st_acc[k][CHUNK-1:0]),
      .b        (st_y[k][CHUNK-1:0]),
      .cin      (st_c[k]),
      .sum      (sum),
      .cout     (cout),
      .c_msb_in (c_msb_unused)
    );

    assign acc_nxt = (st_acc[k] >> CHUNK) | (W'(sum) << (W - CHUNK));

    if (k < STAGES - 1) begin : g_mid
      logic         v_q, v_d;
      logic         c_q, c_d;
      logic [W-1:0] acc_q, acc_d;
      logic [W-1:0] y_q, y_d;

      always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        acc_d = acc_q;
        y_d   = y_q;
        if (adv) begin
          v_d   = st_v[k];
          c_d   = cout;
          acc_d = acc_nxt;
          y_d   = st_y[k] >> CHUNK;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          c_q   <= 1'b0;
          acc_q <= '0;
          y_q   <= '0;
        end else begin
          v_q   <= v_d;
          c_q   <= c_d;
          acc_q <= acc_d;
          y_q   <= y_d;
        end
      end

      assign st_v[k+1]   = v_q;
      assign st_c[k+1]   = c_q;
      assign st_acc[k+1] = acc_q;
      assign st_y[k+1]   = y_q;
    end else begin : g_last
      logic          v_q, v_d;
      logic [W-1:0]  o_q, o_d;
      addsub_flags_t flags_q, flags_d;
      logic [W-1:0]  y_unused;

      assign y_unused = st_y[k];

      always_comb begin
        v_d     = v_q;
        o_d     = o_q;
        flags_d = flags_q;
        if (adv) begin
          v_d              = st_v[k];
          o_d              = acc_nxt;
          flags_d.co       = cout;
          flags_d.overflow = c_msb_unused ^ cout;
          flags_d.zero     = ~|acc_nxt;
          flags_d.neg      = acc_nxt[W-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q     <= 1'b0;
          o_q     <= '0;
          flags_q <= '0;
        end else begin
          v_q     <= v_d;
          o_q     <= o_d;
          flags_q <= flags_d;
        end
      end

      assign out_valid = v_q;
      assign o         = o_q;
      assign co        = flags_q.co;
      assign overflow  = flags_q.overflow;
      assign zero      = flags_q.zero;
      assign neg       = flags_q.neg;
    end
  end

endmodule : addsub_pipe
`default_nettype wire
